// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
// State enum, opcode values, datapath select encodings, ALU op codes
// and the branch-condition helper used by multicycle_controller.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_BRANCH,
      S_JALRADR,
      S_JAL,
      S_LUI,
      S_AUIPC,
      S_TRAP
   } state_t;

   // Which ALU function family the current state asks for.
   typedef enum logic [1:0] {
      ACLS_ADD,
      ACLS_SUB,
      ACLS_RTYPE,
      ACLS_ITYPE
   } alu_class_t;

   // Opcodes (instr[6:0])
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // ALUControl
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;

   // ImmSrc
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // ResultSrc
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;
   localparam logic [1:0] RES_IMMEXT    = 2'b11;

   // ALUSrcA / ALUSrcB
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_A     = 2'b10;
   localparam logic [1:0] SRCB_WD    = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   // Branch decision from the flags of rs1 - rs2.
   // cout=1 means no borrow, i.e. rs1 >= rs2 unsigned.
   function automatic logic branch_taken(input logic [2:0] funct3,
                                         input logic zero, cout, overflow, sign);
      logic lt;
      lt = sign ^ overflow;
      case (funct3)
         3'b000:  branch_taken = zero;
         3'b001:  branch_taken = !zero;
         3'b100:  branch_taken = lt;
         3'b101:  branch_taken = !lt;
         3'b110:  branch_taken = !cout;
         3'b111:  branch_taken = cout;
         default: branch_taken = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: combinational funct3/funct7b5/state-class to ALUControl.
// funct7b5 picks SUB over ADD for R-type only; it picks SRA over SRL
// for both R- and I-type shifts.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  alu_class_t  alu_class,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   output logic [3:0]  alu_control
);

   // Map the requested ALU family and function fields to an ALU op.
   always_comb begin
      // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
      alu_control = ALU_ADD;
      case (alu_class)
         ACLS_ADD: alu_control = ALU_ADD;
         ACLS_SUB: alu_control = ALU_SUB;
         default: begin
            case (funct3)
               3'b000:  alu_control = (alu_class == ACLS_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_control = ALU_SLL;
               3'b010:  alu_control = ALU_SLT;
               3'b011:  alu_control = ALU_SLTU;
               3'b100:  alu_control = ALU_XOR;
               3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_control = ALU_OR;
               default: alu_control = ALU_AND;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM for the multicycle RV32I datapath.
// Sequences each instruction over 3-5 cycles and drives all datapath
// selects and write enables. Optional build macro MEM_WAIT_EN makes FETCH,
// MEMREAD and MEMWRITE stall until mem_ready; without it mem_ready is ignored.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       cout,
   input  logic       overflow,
   input  logic       sign,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       AdrSrc,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ImmSrc,
   output logic [3:0] ALUControl,
   output logic       illegal
);

   state_t     state, next_state;
   alu_class_t alu_class;
   logic       ready;
   logic       pc_write, ir_write, reg_write, mem_write;

`ifdef MEM_WAIT_EN
   assign ready = mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign ready            = 1'b1;
`endif

   // State register; reset returns to FETCH immediately.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: state is updated with <= so every flop samples pre-edge values.
      if (!reset) state <= S_FETCH;
      else        state <= next_state;
   end

   // Next-state logic and Moore outputs (branch PCWrite is the Mealy exception).
   always_comb begin
      next_state = state;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_WD;
      ImmSrc     = IMM_I;
      alu_class  = ACLS_ADD;
      illegal    = 1'b0;
      unique case (state)
         S_FETCH: begin
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            ir_write  = ready;
            pc_write  = ready;
            if (ready) next_state = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = IMM_B;
            case (op)
               OP_LOAD, OP_STORE: next_state = S_MEMADR;
               OP_RTYPE:          next_state = S_EXECUTER;
               OP_ITYPE:          next_state = S_EXECUTEI;
               OP_BRANCH:         next_state = S_BRANCH;
               OP_JAL:            next_state = S_JAL;
               OP_JALR:           next_state = S_JALRADR;
               OP_LUI:            next_state = S_LUI;
               OP_AUIPC:          next_state = S_AUIPC;
               default:           next_state = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_A;
            ALUSrcB = SRCB_IMM;
            if (op == OP_STORE) begin
               ImmSrc     = IMM_S;
               next_state = S_MEMWRITE;
            end else begin
               next_state = S_MEMREAD;
            end
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            if (ready) next_state = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc  = RES_DATA;
            reg_write  = 1'b1;
            next_state = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc    = 1'b1;
            mem_write = ready;
            if (ready) next_state = S_FETCH;
         end
         S_EXECUTER: begin
            ALUSrcA    = SRCA_A;
            alu_class  = ACLS_RTYPE;
            next_state = S_ALUWB;
         end
         S_EXECUTEI: begin
            ALUSrcA    = SRCA_A;
            ALUSrcB    = SRCB_IMM;
            alu_class  = ACLS_ITYPE;
            next_state = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write  = 1'b1;
            next_state = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA    = SRCA_A;
            alu_class  = ACLS_SUB;
            pc_write   = branch_taken(funct3, Zero, cout, overflow, sign);
            next_state = S_FETCH;
         end
         S_JALRADR: begin
            ALUSrcA    = SRCA_A;
            ALUSrcB    = SRCB_IMM;
            next_state = S_JAL;
         end
         S_JAL: begin
            ALUSrcA    = SRCA_OLDPC;
            ALUSrcB    = SRCB_FOUR;
            ImmSrc     = IMM_J;
            pc_write   = 1'b1;
            next_state = S_ALUWB;
         end
         S_LUI: begin
            ImmSrc     = IMM_U;
            ResultSrc  = RES_IMMEXT;
            reg_write  = 1'b1;
            next_state = S_FETCH;
         end
         S_AUIPC: begin
            ALUSrcA    = SRCA_OLDPC;
            ALUSrcB    = SRCB_IMM;
            ImmSrc     = IMM_U;
            next_state = S_ALUWB;
         end
         S_TRAP: begin
            illegal    = 1'b1;
            next_state = S_TRAP;
         end
         default: next_state = S_FETCH;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_class   (alu_class),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .alu_control (ALUControl)
   );

   // Write enables are held off for as long as reset is asserted.
   assign PCWrite  = pc_write  & reset;
   assign IRWrite  = ir_write  & reset;
   assign RegWrite = reg_write & reset;
   assign MemWrite = mem_write & reset;

endmodule
